reg_file_param: RTL

- Parametrised successor to the 16x16 two-read/one-write register file.
- Generalises data width and depth.
- Adds registered reads with write-to-read bypass, an optional hardwired-zero entry, and a sequential clear-sweep engine that zeroes the array without a reset.
- Sits as the general-purpose operand store in datapath assignments.

---
 rtl/reg_file_param.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 2R/1W register file: registered write-first reads, optional zero entry, clear sweep
// Defining REGFILE_PARITY_EN adds per-entry even parity with par_inj/par_err ports.
module reg_file_param #(
    parameter int W        = 16,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wren,
    input  logic [AW-1:0] wrad,
    input  logic [W-1:0]  wrdt,
    input  logic [AW-1:0] rd1ad,
    input  logic [AW-1:0] rd2ad,
    output logic [W-1:0]  rd1dt,
    output logic [W-1:0]  rd2dt,
    input  logic          clr_start,
    output logic          busy,
`ifdef REGFILE_PARITY_EN
    input  logic          par_inj,
    output logic          par_err,
`endif
    output logic          wr_drop
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic [W-1:0]  mem [DEPTH];

    logic          in_sweep;
    logic          user_wr;
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic          rd1_zero;
    logic          rd2_zero;
    logic          rd1_byp;
    logic          rd2_byp;

    assign in_sweep = (state == SWEEP);
    assign busy     = in_sweep;

    // The user port and the sweep engine never write in the same cycle, so they share one write path.
    assign user_wr = wren && !in_sweep && !((ZERO_REG != 0) && (wrad == '0));
    assign we      = user_wr || in_sweep;
    assign wa      = in_sweep ? cnt : wrad;
    assign wd      = in_sweep ? '0 : wrdt;

    assign rd1_zero = (ZERO_REG != 0) && (rd1ad == '0);
    assign rd2_zero = (ZERO_REG != 0) && (rd2ad == '0);
    assign rd1_byp  = we && (wa == rd1ad);
    assign rd2_byp  = we && (wa == rd2ad);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= SWEEP;
                        cnt   <= '0;
                    end
                end
                SWEEP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1dt   <= '0;
            rd2dt   <= '0;
            wr_drop <= 1'b0;
        end else begin
            rd1dt   <= rd1_zero ? '0 : (rd1_byp ? wd : mem[rd1ad]);
            rd2dt   <= rd2_zero ? '0 : (rd2_byp ? wd : mem[rd2ad]);
            wr_drop <= wren && in_sweep;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic pmem [DEPTH];
    logic pd;
    logic rd1_bad;
    logic rd2_bad;

    // Sweep stores parity 0, which matches the all-zero data it writes.
    assign pd      = in_sweep ? 1'b0 : ((^wrdt) ^ par_inj);
    assign rd1_bad = !rd1_zero && !rd1_byp && ((^mem[rd1ad]) != pmem[rd1ad]);
    assign rd2_bad = !rd2_zero && !rd2_byp && ((^mem[rd2ad]) != pmem[rd2ad]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pmem[i] <= 1'b0;
            end
            par_err <= 1'b0;
        end else begin
            if (we) begin
                pmem[wa] <= pd;
            end
            par_err <= rd1_bad || rd2_bad;
        end
    end
`endif

endmodule
